mm_bus_arbiter: RTL and testbench
=================================

Name: mm_bus_arbiter

Overview:
- Shares one memory-mapped slave port between NUM_MASTERS requesters, typically several riscVsim virtual-processor nodes driving one memory or peripheral model.
- Round-robin arbitration with one transaction in flight at a time.
- Returns read data to the owning master, stalls all other masters via waitrequest, and times out reads the slave never answers.

Parameters:
- NUM_MASTERS, 2, number of requesters, legal range 2..8.
- TIMEOUT, 256, cycles to wait for s_readdatavalid after read acceptance; 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF, data returned to the master on a read timeout.

Ports:
- clk  in  1  rising-edge clock for all logic.
- reset  in  1  synchronous, active-high.
- m_address  in  32*NUM_MASTERS  per-master byte address; master i in bits [32i+31:32i].
- m_write  in  NUM_MASTERS  write request, held until the master's waitrequest is low.
- m_writedata  in  32*NUM_MASTERS  write data.
- m_byteenable  in  4*NUM_MASTERS  byte lane enables.
- m_read  in  NUM_MASTERS  read request, held until the master's waitrequest is low.
- m_waitrequest  out  NUM_MASTERS  high = command not yet accepted.
- m_readdata  out  32  read data, shared by all masters.
- m_readdatavalid  out  NUM_MASTERS  one-cycle pulse to the owning master.
- m_timeout  out  NUM_MASTERS  one-cycle pulse, coincident with m_readdatavalid, on a timed-out read.
- s_address  out  32  slave address.
- s_write  out  1  slave write strobe.
- s_writedata  out  32  slave write data.
- s_byteenable  out  4  slave byte enables.
- s_read  out  1  slave read strobe.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data.
- s_readdatavalid  in  1  slave read response.
- grant  out  3  index of the current or last owner.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset values:
  - state IDLE; all s_* outputs 0.
  - m_waitrequest all 1s; m_readdatavalid, m_timeout 0; m_readdata 0.
  - grant = NUM_MASTERS-1, so master 0 wins first; busy 0; timeout counter 0.
- Requests: req[i] = m_write[i] | m_read[i]. If both are set, the write is performed and the read is ignored for that grant (illegal stimulus; the bench flags it).
- FSM states: IDLE, CMD, RD_WAIT.
- IDLE:
  - If any req, pick the first requester after grant, searching upward with wrap.
  - Register the winner's address, writedata, byteenable and op, update grant, then go to CMD.
  - Latency: request seen in cycle N, slave command driven in N+1.
- CMD:
  - Drive s_* from the captured values; s_write or s_read = 1.
  - When s_waitrequest = 0 that cycle, m_waitrequest[grant] = 0 combinationally (accept handshake). The master drops its request next cycle.
  - On accept: a write goes to IDLE; a read goes to RD_WAIT with the counter cleared.
  - While s_waitrequest = 1, stay in CMD and hold all s_* stable.
- RD_WAIT:
  - s_read = 0; the counter increments each cycle.
  - On s_readdatavalid: m_readdata = s_readdata and m_readdatavalid[grant] = 1, both registered (one cycle after s_readdatavalid). Then go to IDLE.
  - If the counter reaches TIMEOUT-1 with no valid: registered m_readdata = ERR_DATA, m_readdatavalid[grant] = 1, m_timeout[grant] = 1. Then go to IDLE.
  - If valid and the timeout land on the same cycle, valid wins and no timeout is flagged.
- Non-granted masters: m_waitrequest = 1 always.
- Fairness: a master requesting continuously waits at most NUM_MASTERS-1 transactions.
- Bus cycle timing: minimum 2 cycles per write; minimum 3 cycles plus slave latency per read.
- Stray s_readdatavalid in IDLE or CMD is ignored. A late response after a timeout that lands in a later RD_WAIT is mis-attributed; this is a documented slave-protocol violation.
- Reset mid-operation: return to IDLE with reset values next edge. A pending slave response is dropped, and no master sees readdatavalid.
- grant width is fixed at 3; upper bits are 0 when NUM_MASTERS ≤ 4.

Decomposition:
- Shared package mm_bus_pkg:
  - state encodings (IDLE = 0, CMD = 1, RD_WAIT = 2);
  - default ERR_DATA;
  - address/data/byteenable width constants.
- Sub-module rr_arbiter holds the round-robin priority search: inputs req[NUM_MASTERS] and last grant, outputs one-hot winner and index. It is purely combinational; the pointer register stays in mm_bus_arbiter.

Test Plan:
- Reset: after 2 reset cycles → m_waitrequest = 2'b11, all s_* 0, busy 0, grant = 1.
- Single write: M0 writes addr 0x00001000, data 0x12345678, be 0xF, with s_waitrequest = 0 → s_write high exactly one cycle with those values; m_waitrequest[0] low that same cycle; busy drops next cycle.
- Contention: M0 and M1 read simultaneously; slave answers 0xA5A5A5A5 then 0x5A5A5A5A after 2 cycles each → M0 served first, then M1. Each m_readdatavalid is a single pulse on the correct bit with the correct data; M1's waitrequest stays high throughout M0's transaction.
- Fairness and stall: both masters request continuously for 6 transactions with s_waitrequest high 3 cycles per command → grant sequence 0,1,0,1,0,1; s_* stable during each stall.
- Timeout: TIMEOUT = 16, M1 reads and the slave never responds → 16 cycles after acceptance, m_readdata = 0xDEADBEEF, m_readdatavalid[1] = m_timeout[1] = 1 for one cycle; a later stray s_readdatavalid in IDLE produces no output.
- Reset mid-read: assert reset in RD_WAIT, then pulse s_readdatavalid → no m_readdatavalid; all outputs return to reset values; the next request is granted to master 0.

Source files
------------

// File: rtl/mm_bus_pkg.sv
// Shared types and constants for the memory-mapped bus arbiter.
// Holds the FSM state encoding, bus widths and the default read-timeout data word.
package mm_bus_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int GRANT_W = 3;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search over the request vector.
// Priority starts at the master after i_last and wraps upward; the pointer register lives in the caller.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_last,
    output logic [N-1:0] o_onehot,
    output logic [2:0]   o_idx,
    output logic         o_valid
);

    always_comb begin
        o_valid  = 1'b0;
        o_idx    = i_last;
        o_onehot = '0;
        // Outer loop is the priority order, so the first hit is the nearest requester after i_last.
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_valid && i_req[j] && (((int'(i_last) + 1 + k) % N) == j)) begin
                    o_valid = 1'b1;
                    o_idx   = 3'(j);
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            o_onehot[j] = o_valid && (o_idx == 3'(j));
        end
    end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Shares one memory-mapped slave between NUM_MASTERS requesters, one transaction in flight.
// Round-robin grant, combinational accept handshake, registered read return with timeout.
//
// state   | meaning
// IDLE    | no transaction; arbitrate among requesters
// CMD     | command driven on slave port until s_waitrequest drops
// RD_WAIT | read accepted; waiting for s_readdatavalid or timeout
module mm_bus_arbiter
    import mm_bus_pkg::*;
#(
    parameter int                NUM_MASTERS = 2,
    parameter int                TIMEOUT     = 256,
    parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_writedata,
    input  logic [BE_W*NUM_MASTERS-1:0]   m_byteenable,
    input  logic [NUM_MASTERS-1:0]        m_read,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [NUM_MASTERS-1:0]        m_timeout,
    output logic [ADDR_W-1:0]             s_address,
    output logic                          s_write,
    output logic [DATA_W-1:0]             s_writedata,
    output logic [BE_W-1:0]               s_byteenable,
    output logic                          s_read,
    input  logic                          s_waitrequest,
    input  logic [DATA_W-1:0]             s_readdata,
    input  logic                          s_readdatavalid,
    output logic [GRANT_W-1:0]            grant,
    output logic                          busy
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t                   r_state;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [BE_W-1:0]          r_be;
    logic                     r_op_wr;
    logic [GRANT_W-1:0]       r_grant;
    logic [DATA_W-1:0]        r_rdata;
    logic [NUM_MASTERS-1:0]   r_rdv;
    logic [NUM_MASTERS-1:0]   r_to;
    logic [31:0]              r_cnt;

    logic [NUM_MASTERS-1:0]   w_req;
    logic [NUM_MASTERS-1:0]   w_win_oh;
    logic [GRANT_W-1:0]       w_win_idx;
    logic                     w_win_valid;
    logic [NUM_MASTERS-1:0]   w_grant_oh;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [DATA_W-1:0]        w_sel_wdata;
    logic [BE_W-1:0]          w_sel_be;
    logic                     w_sel_wr;
    logic                     w_accept;

    // A master asserting both write and read gets the write; the read is dropped for that grant.
    assign w_req = m_write | m_read;

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .i_req    (w_req),
        .i_last   (r_grant),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        w_sel_wr    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_win_oh[i]) begin
                w_sel_addr  = m_address[ADDR_W*i +: ADDR_W];
                w_sel_wdata = m_writedata[DATA_W*i +: DATA_W];
                w_sel_be    = m_byteenable[BE_W*i +: BE_W];
                w_sel_wr    = m_write[i];
            end
        end
    end

    assign w_accept = (r_state == CMD) && !s_waitrequest && !reset;

    always_comb begin
        w_grant_oh    = '0;
        m_waitrequest = '1;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            w_grant_oh[j]    = (r_grant == 3'(j));
            m_waitrequest[j] = !(w_accept && (r_grant == 3'(j)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_op_wr <= 1'b0;
            r_grant <= 3'(NUM_MASTERS - 1);
            r_rdata <= '0;
            r_rdv   <= '0;
            r_to    <= '0;
            r_cnt   <= '0;
        end else begin
            r_rdv <= '0;
            r_to  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_be    <= w_sel_be;
                        r_op_wr <= w_sel_wr;
                        r_grant <= w_win_idx;
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (!s_waitrequest) begin
                        r_cnt   <= '0;
                        r_state <= r_op_wr ? IDLE : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    // A real response in the same cycle as expiry wins over the timeout.
                    if (s_readdatavalid) begin
                        r_rdata <= s_readdata;
                        r_rdv   <= w_grant_oh;
                        r_state <= IDLE;
                    end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
                        r_rdata <= ERR_DATA;
                        r_rdv   <= w_grant_oh;
                        r_to    <= w_grant_oh;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_address       = r_addr;
    assign s_writedata     = r_wdata;
    assign s_byteenable    = r_be;
    assign s_write         = (r_state == CMD) && r_op_wr;
    assign s_read          = (r_state == CMD) && !r_op_wr;
    assign grant           = r_grant;
    assign busy            = (r_state != IDLE);
    assign m_readdata      = r_rdata;
    assign m_readdatavalid = r_rdv;
    assign m_timeout       = r_to;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter with two masters and a short read timeout.
// Read responses are checked against a scoreboard queue filled as requests are issued.
module tb_mm_bus_arbiter;

    localparam int NM = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] m_address = '0;
    logic [1:0]  m_write = '0;
    logic [63:0] m_writedata = '0;
    logic [7:0]  m_byteenable = '0;
    logic [1:0]  m_read = '0;
    logic [1:0]  m_waitrequest;
    logic [31:0] m_readdata;
    logic [1:0]  m_readdatavalid;
    logic [1:0]  m_timeout;
    logic [31:0] s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_waitrequest = 1'b0;
    logic [31:0] s_readdata = '0;
    logic        s_readdatavalid = 1'b0;
    logic [2:0]  grant;
    logic        busy;

    mm_bus_arbiter #(
        .NUM_MASTERS (NM),
        .TIMEOUT     (TO),
        .ERR_DATA    (32'hDEADBEEF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m_address       (m_address),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_timeout       (m_timeout),
        .s_address       (s_address),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .grant           (grant),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] d;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    int   exp_g[$];
    rsp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wreq"}, 64'(m_waitrequest), 64'(2'b11));
        chk({tag, "_s_addr_data"}, {s_address, s_writedata}, 64'd0);
        chk({tag, "_s_ctl"}, 64'({s_write, s_read, s_byteenable}), 64'd0);
        chk({tag, "_busy_grant"}, 64'({busy, grant}), 64'({1'b0, 3'd1}));
        chk({tag, "_rsp"}, 64'({m_readdatavalid, m_timeout, m_readdata}), 64'd0);
    endtask

    // Every read-return pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (m_readdatavalid !== 2'b00 || m_timeout !== 2'b00)) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'({m_readdatavalid, m_timeout}), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid", 64'(m_readdatavalid), 64'((mon_e.m == 0) ? 2'b01 : 2'b10));
                chk("rsp_data", 64'(m_readdata), 64'(mon_e.d));
                chk("rsp_timeout", 64'(m_timeout),
                    64'(mon_e.to ? ((mon_e.m == 0) ? 2'b01 : 2'b10) : 2'b00));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          g;
        int          gm;
        int          k[2];
        logic [31:0] a;
        logic [31:0] d;

        repeat (2) cyc();
        check_reset("rst");
        reset = 1'b0;

        // Contention: both masters read together, master 0 first.
        m_address = {32'h0000_3000, 32'h0000_2000};
        m_read    = 2'b11;
        sb.push_back('{0, 32'hA5A5A5A5, 1'b0});
        sb.push_back('{1, 32'h5A5A5A5A, 1'b0});
        cyc();
        chk("cont_addr0", 64'(s_address), 64'h2000);
        chk("cont_ctl0", 64'({s_read, s_write, grant, m_waitrequest}), 64'({1'b1, 1'b0, 3'd0, 2'b10}));
        cyc();
        m_read[0] = 1'b0;
        chk("cont_hold1_a", 64'({m_waitrequest, s_read}), 64'({2'b11, 1'b0}));
        cyc();
        s_readdatavalid = 1'b1;
        s_readdata      = 32'hA5A5A5A5;
        chk("cont_hold1_b", 64'(m_waitrequest), 64'(2'b11));
        cyc();
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
        chk("cont_hold1_c", 64'(m_waitrequest), 64'(2'b11));
        cyc();
        chk("cont_addr1", 64'(s_address), 64'h3000);
        chk("cont_ctl1", 64'({s_read, s_write, grant, m_waitrequest}), 64'({1'b1, 1'b0, 3'd1, 2'b01}));
        cyc();
        m_read[1] = 1'b0;
        cyc();
        s_readdatavalid = 1'b1;
        s_readdata      = 32'h5A5A5A5A;
        cyc();
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
        cyc();
        cyc();
        chk("cont_sb_empty", 64'(sb.size()), 64'd0);

        // Fairness: continuous writes from both masters, each command stalled 3 cycles.
        g = 1;
        for (int t = 0; t < 6; t++) begin
            g = (g + 1) % NM;
            exp_g.push_back(g);
        end
        k[0] = 0;
        k[1] = 0;
        s_waitrequest = 1'b1;
        m_address     = {32'h0000_0200, 32'h0000_0100};
        m_writedata   = {32'hB000_0000, 32'hA000_0000};
        m_byteenable  = 8'hFF;
        m_write       = 2'b11;
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (s_write !== 1'b1 && n < 20) begin
                cyc();
                n++;
            end
            gm = exp_g.pop_front();
            a  = ((gm == 0) ? 32'h100 : 32'h200) + 32'(4 * k[gm]);
            d  = (gm == 0) ? 32'hA000_0000 : 32'hB000_0000;
            chk("fair_grant", 64'(grant), 64'(3'(gm)));
            chk("fair_wdata", 64'(s_writedata), 64'(d));
            for (int s = 0; s < 3; s++) begin
                chk("fair_hold", 64'({s_write, s_address, m_waitrequest, s_byteenable}),
                    64'({1'b1, a, 2'b11, 4'hF}));
                cyc();
            end
            s_waitrequest = 1'b0;
            #1;
            chk("fair_accept", 64'({s_address, m_waitrequest}),
                64'({a, ((gm == 0) ? 2'b10 : 2'b01)}));
            cyc();
            s_waitrequest = 1'b1;
            k[gm]++;
            m_address[32*gm +: 32] = ((gm == 0) ? 32'h100 : 32'h200) + 32'(4 * k[gm]);
            if (t == 5) m_write = 2'b00;
        end
        s_waitrequest = 1'b0;
        cyc();

        // Single write from master 0 with no slave stall.
        m_address[31:0]   = 32'h0000_1000;
        m_writedata[31:0] = 32'h1234_5678;
        m_byteenable[3:0] = 4'hF;
        m_write           = 2'b01;
        cyc();
        chk("wr_addr_data", {s_address, s_writedata}, {32'h0000_1000, 32'h1234_5678});
        chk("wr_ctl", 64'({s_write, s_read, s_byteenable, m_waitrequest, busy, grant}),
            64'({1'b1, 1'b0, 4'hF, 2'b10, 1'b1, 3'd0}));
        cyc();
        m_write = 2'b00;
        chk("wr_done", 64'({s_write, busy}), 64'd0);

        // Timeout: master 1 reads and the slave never answers.
        m_address[63:32] = 32'h0000_4000;
        m_read           = 2'b10;
        sb.push_back('{1, 32'hDEADBEEF, 1'b1});
        cyc();
        chk("to_accept", 64'({s_read, m_waitrequest}), 64'({1'b1, 2'b01}));
        cyc();
        m_read = 2'b00;
        n = 1;
        while (m_timeout[1] !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        // TIMEOUT cycles spent in RD_WAIT, then one more for the registered pulse.
        chk("to_latency", 64'(n), 64'(TO + 1));
        chk("to_pulse", 64'({m_readdatavalid, m_timeout, m_readdata}), 64'({2'b10, 2'b10, 32'hDEADBEEF}));
        cyc();
        chk("to_single", 64'({m_readdatavalid, m_timeout, busy}), 64'd0);
        s_readdatavalid = 1'b1;
        s_readdata      = 32'h1111_1111;
        cyc();
        s_readdatavalid = 1'b0;
        chk("stray_idle", 64'({m_readdatavalid, m_timeout, busy}), 64'd0);

        // Reset while a read is outstanding; the late response must vanish.
        m_address[31:0] = 32'h0000_5000;
        m_read          = 2'b01;
        cyc();
        cyc();
        m_read = 2'b00;
        chk("rmr_in_rdwait", 64'({busy, s_read}), 64'({1'b1, 1'b0}));
        reset = 1'b1;
        cyc();
        reset           = 1'b0;
        s_readdatavalid = 1'b1;
        s_readdata      = 32'h7777_7777;
        check_reset("rmr");
        cyc();
        s_readdatavalid = 1'b0;
        chk("rmr_no_rsp", 64'({m_readdatavalid, m_timeout, m_readdata, busy}), 64'd0);
        m_address = {32'h0000_6100, 32'h0000_6000};
        m_write   = 2'b11;
        cyc();
        chk("rmr_next_grant", 64'({grant, s_write, s_address}), 64'({3'd0, 1'b1, 32'h0000_6000}));
        cyc();
        m_write = 2'b00;
        cyc();
        cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
